// File: rtl/fp_to_int_seq.sv
// rtl/fp_to_int_seq.sv - iterative IEEE-754 single to signed 32-bit integer converter (option: FP2I_ROUND_NEAREST_EN)
module fp_to_int_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        ovf,
  output logic        nan,
  output logic        inexact
);

`ifdef FP2I_ROUND_NEAREST_EN
  localparam logic       RNE   = 1'b1;
  localparam logic [7:0] E_MIN = 8'd126;
`else
  localparam logic       RNE   = 1'b0;
  localparam logic [7:0] E_MIN = 8'd127;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t      state_q, state_n;
  logic [31:0] mag_q, mag_n;
  logic        guard_q, guard_n;
  logic        sticky_q, sticky_n;
  logic [4:0]  cnt_q, cnt_n;
  logic        dir_q, dir_n;     // 1 = shift left, 0 = shift right
  logic        sign_q, sign_n;
  logic [31:0] c_n;
  logic        ovf_n, nan_n, inexact_n;

  logic        sg;
  logic [7:0]  ex;
  logic [22:0] man;
  logic [31:0] m_t, mag_r;
  logic        g_t, s_t, inc;
  logic [4:0]  k_t;

  assign in_ready  = (state_q == IDLE) && rst;
  assign out_valid = (state_q == DONE);
  assign sg  = a[31];
  assign ex  = a[30:23];
  assign man = a[22:0];

  // Next-state and datapath: decode on accept, shift up to STEP bits per cycle, round/negate in FIX
  always_comb begin
    state_n   = state_q;
    mag_n     = mag_q;
    guard_n   = guard_q;
    sticky_n  = sticky_q;
    cnt_n     = cnt_q;
    dir_n     = dir_q;
    sign_n    = sign_q;
    c_n       = c;
    ovf_n     = ovf;
    nan_n     = nan;
    inexact_n = inexact;
    m_t       = mag_q;
    g_t       = guard_q;
    s_t       = sticky_q;
    k_t       = cnt_q;
    inc       = 1'b0;
    mag_r     = mag_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ovf_n     = 1'b0;
          nan_n     = 1'b0;
          inexact_n = 1'b0;
          sign_n    = sg;
          if (ex == 8'hFF && man != 23'd0) begin
            c_n     = 32'h7FFF_FFFF;
            nan_n   = 1'b1;
            state_n = DONE;
          end else if (ex == 8'hFF) begin
            c_n     = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf_n   = 1'b1;
            state_n = DONE;
          end else if (ex == 8'd158 && sg && man == 23'd0) begin
            // exactly -2^31 is representable
            c_n     = 32'h8000_0000;
            state_n = DONE;
          end else if (ex >= 8'd158) begin
            c_n     = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf_n   = 1'b1;
            state_n = DONE;
          end else if (ex < E_MIN) begin
            // denormals fold into this branch as zero
            c_n       = 32'd0;
            inexact_n = (ex != 8'd0) || (man != 23'd0);
            state_n   = DONE;
          end else begin
            mag_n    = {9'd0, 1'b1, man};
            guard_n  = 1'b0;
            sticky_n = 1'b0;
            if (ex >= 8'd150) begin
              dir_n = 1'b1;
              cnt_n = 5'(ex - 8'd150);
            end else begin
              dir_n = 1'b0;
              cnt_n = 5'(8'd150 - ex);
            end
            state_n = (ex == 8'd150) ? FIX : SHIFT;
          end
        end
      end
      SHIFT: begin
        for (int i = 0; i < STEP; i++) begin
          if (k_t != 5'd0) begin
            if (dir_q) begin
              m_t = {m_t[30:0], 1'b0};
            end else begin
              s_t = s_t | g_t;
              g_t = m_t[0];
              m_t = {1'b0, m_t[31:1]};
            end
            k_t = k_t - 5'd1;
          end
        end
        mag_n    = m_t;
        guard_n  = g_t;
        sticky_n = s_t;
        cnt_n    = k_t;
        if (k_t == 5'd0) state_n = FIX;
      end
      FIX: begin
        inc       = RNE && guard_q && (sticky_q || mag_q[0]);
        mag_r     = mag_q + {31'd0, inc};
        c_n       = sign_q ? (~mag_r + 32'd1) : mag_r;
        inexact_n = guard_q | sticky_q;
        state_n   = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  // Datapath and result registers; reset clears the visible result and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      mag_q    <= 32'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 5'd0;
      dir_q    <= 1'b0;
      sign_q   <= 1'b0;
      c        <= 32'd0;
      ovf      <= 1'b0;
      nan      <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      mag_q    <= mag_n;
      guard_q  <= guard_n;
      sticky_q <= sticky_n;
      cnt_q    <= cnt_n;
      dir_q    <= dir_n;
      sign_q   <= sign_n;
      c        <= c_n;
      ovf      <= ovf_n;
      nan      <= nan_n;
      inexact  <= inexact_n;
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// tb/tb_fp_to_int_seq.sv - self-checking bench for fp_to_int_seq
module tb_fp_to_int_seq;

  localparam int STEP0 = 1;

`ifdef FP2I_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, c;
  logic        ovf, nan, inexact;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] a4, c4;
  logic        ovf4, nan4, inexact4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] c;
    logic        ovf;
    logic        nan;
    logic        inx;
    logic [7:0]  lat;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] ct;
    logic [31:0] cr;
    logic        ov;
    logic        na;
    logic        ix;
    int          lt;
    int          lr;
  } vec_t;

  fp_to_int_seq #(.STEP(STEP0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf), .nan(nan), .inexact(inexact)
  );

  fp_to_int_seq #(.STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4),
    .out_valid(out_valid4), .out_ready(out_ready4), .c(c4), .ovf(ovf4), .nan(nan4), .inexact(inexact4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: value = {1,M} * 2^(e-23) held as 32.32 fixed point, then truncate or round-half-even
  function automatic res_t model(input logic [31:0] x, input int step);
    res_t        r;
    logic [7:0]  ee;
    logic [22:0] mm;
    logic [63:0] fx;
    logic [31:0] ip, fr;
    int          e, cnt;
    r  = '0;
    ee = x[30:23];
    mm = x[22:0];
    r.lat = 8'd1;
    if (ee == 8'hFF && mm != 0) begin
      r.c = 32'h7FFF_FFFF; r.nan = 1'b1;
    end else if (ee == 8'hFF) begin
      r.c = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1'b1;
    end else if (ee == 8'd158 && x[31] && mm == 0) begin
      r.c = 32'h8000_0000;
    end else if (ee >= 8'd158) begin
      r.c = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; r.ovf = 1'b1;
    end else if (int'(ee) < (RNE ? 126 : 127)) begin
      r.c = 32'd0; r.inx = (ee != 0) || (mm != 0);
    end else begin
      e  = int'(ee) - 127;
      fx = 64'({1'b1, mm}) << (e + 9);
      ip = fx[63:32];
      fr = fx[31:0];
      r.inx = (fr != 0);
      if (RNE && (fr > 32'h8000_0000 || (fr == 32'h8000_0000 && ip[0]))) ip = ip + 1;
      r.c = x[31] ? -ip : ip;
      cnt = (e >= 23) ? e - 23 : 23 - e;
      r.lat = 8'(2 + (cnt + step - 1) / step);
    end
    return r;
  endfunction

  // Compare process: every cycle out_valid is high the DUT must show the queued expectation
  res_t exp_q[$];
  int   acc_cyc = 0;
  bit   seen = 0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      seen = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, STEP0));
        acc_cyc = cyc;
        seen = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          chk("cmp_c", c, exp_q[0].c);
          chk("cmp_ovf", ovf, exp_q[0].ovf);
          chk("cmp_nan", nan, exp_q[0].nan);
          chk("cmp_inexact", inexact, exp_q[0].inx);
          if (!seen) chk("cmp_latency", cyc - acc_cyc, 32'(exp_q[0].lat));
          seen = 1;
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic run(input logic [31:0] x, output logic [31:0] cg);
    int n;
    @(posedge clk); #1;
    a = x; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 300);
    if (!out_valid) chk("timeout_out_valid", 32'd1, 32'd0);
    cg = c;
  endtask

  vec_t vecs[] = '{
    '{32'h4049_0FDB, 32'd3,         32'd3,         1'b0, 1'b0, 1'b1, 24, 24},
    '{32'hC2F6_0000, 32'hFFFF_FF85, 32'hFFFF_FF85, 1'b0, 1'b0, 1'b0, 19, 19},
    '{32'h4F00_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1,  1},
    '{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1,  1},
    '{32'h7FC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1,  1},
    '{32'hFF80_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1,  1},
    '{32'h3FC0_0000, 32'd1,         32'd2,         1'b0, 1'b0, 1'b1, 25, 25},
    '{32'h4020_0000, 32'd2,         32'd2,         1'b0, 1'b0, 1'b1, 24, 24},
    '{32'hBF40_0000, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1,  26},
    '{32'h3F00_0000, 32'd0,         32'd0,         1'b0, 1'b0, 1'b1, 1,  26},
    '{32'h4120_0000, 32'd10,        32'd10,        1'b0, 1'b0, 1'b0, 22, 22},
    '{32'h4B00_0000, 32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0, 2,  2},
    '{32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 9,  9},
    '{32'h0000_0001, 32'd0,         32'd0,         1'b0, 1'b0, 1'b1, 1,  1},
    '{32'h0000_0000, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 1,  1},
    '{32'hCF80_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1,  1}
  };

  initial begin
    res_t        r;
    logic [31:0] cg;
    int          n;
    rst = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b1;
    a4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_nan", nan, 0);
    chk("rst_inexact", inexact, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    foreach (vecs[i]) begin
      r = model(vecs[i].a, STEP0);
      chk($sformatf("pin_c_%h", vecs[i].a), r.c, RNE ? vecs[i].cr : vecs[i].ct);
      chk($sformatf("pin_ovf_%h", vecs[i].a), r.ovf, vecs[i].ov);
      chk($sformatf("pin_nan_%h", vecs[i].a), r.nan, vecs[i].na);
      chk($sformatf("pin_inx_%h", vecs[i].a), r.inx, vecs[i].ix);
      chk($sformatf("pin_lat_%h", vecs[i].a), 32'(r.lat), 32'(RNE ? vecs[i].lr : vecs[i].lt));
      run(vecs[i].a, cg);
      chk($sformatf("direct_c_%h", vecs[i].a), cg, RNE ? vecs[i].cr : vecs[i].ct);
    end

    // Backpressure: result held for 5 cycles, pulsed in_valid must be ignored
    @(posedge clk); #1;
    a = 32'h4049_0FDB; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 300);
    chk("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 2);
      a = (i == 2) ? 32'h4120_0000 : 32'h4049_0FDB;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_c_held", c, 32'd3);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);

    // Reset during SHIFT discards the operation
    @(posedge clk); #1;
    a = 32'h4049_0FDB; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_nan", nan, 0);
    chk("midrst_inexact", inexact, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", in_ready, 1);
    run(32'h4120_0000, cg);
    chk("midrst_fresh_c", cg, 32'd10);

    // STEP=4 instance latency on -123.0
    @(posedge clk); #1;
    a4 = 32'hC2F6_0000; in_valid4 = 1'b1;
    @(negedge clk);
    chk("s4_in_ready", in_ready4, 1);
    @(posedge clk); #1 in_valid4 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid4 && n < 300);
    chk("s4_latency", n, 7);
    chk("s4_c", c4, 32'hFFFF_FF85);
    chk("s4_inexact", inexact4, 0);
    chk("s4_ovf", ovf4, 0);
    chk("s4_nan", nan4, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
